ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single-write/single-read-port word RAM (combinational read, posedge write) between two requesters.
- Master 0 is the instruction fetch unit and is read-only. Master 1 is the load/store unit and can read or write.
- Requests use a valid/ready handshake. Responses are registered and held until the requester accepts them.
- Byte-masked writes are done as a same-cycle read-modify-write.

Parameters:
- ADDR_SIZE, 12, word address width (matches RAM).
- DATA_SIZE, 32, data word width; must be a multiple of 8.

Ports:
- sys_clk  in  1  clock, all state updates on posedge.
- sys_rst  in  1  reset, synchronous, active-high.
- m0_req_valid  in  1  IFU read request.
- m0_req_ready  out  1  IFU request accepted this cycle.
- m0_addr  in  ADDR_SIZE  IFU word address.
- m0_resp_valid  out  1  IFU read data valid.
- m0_resp_ready  in  1  IFU consumes response.
- m0_rdata  out  DATA_SIZE  IFU read data.
- m1_req_valid  in  1  LSU request.
- m1_req_ready  out  1  LSU request accepted this cycle.
- m1_wr  in  1  1 = write, 0 = read.
- m1_addr  in  ADDR_SIZE  LSU word address.
- m1_wdata  in  DATA_SIZE  LSU write data.
- m1_wstrb  in  DATA_SIZE/8  byte write enables.
- m1_resp_valid  out  1  LSU response (read data or write ack).
- m1_resp_ready  in  1  LSU consumes response.
- m1_rdata  out  DATA_SIZE  LSU read data; 0 for write responses.
- ram_raddr  out  ADDR_SIZE  to RAM raddr.
- ram_waddr  out  ADDR_SIZE  to RAM waddr.
- ram_wdata  out  DATA_SIZE  to RAM wdata.
- ram_wen  out  1  to RAM wen.
- ram_rdata  in  DATA_SIZE  from RAM rdata (combinational).

Behaviour:
- State machine with two states, IDLE and RESP.
- Reset (sys_rst=1 at posedge):
  - state=IDLE, last_grant=1 (so m0 wins the first contention).
  - Both resp_valid=0, both rdata regs=0.
  - Any in-flight response is dropped.
  - ram_wen is combinationally 0 while sys_rst=1.
- IDLE, grant selection:
  - Only m0 valid → grant m0. Only m1 valid → grant m1.
  - Both valid → grant the master not equal to last_grant (round-robin).
  - Exactly one req_ready is asserted, in the same cycle, and only in IDLE.
  - The granted request's addr drives ram_raddr and ram_waddr.
- IDLE, granted read:
  - ram_rdata is latched into the granted master's rdata reg at posedge.
- IDLE, granted m1 write:
  - ram_wdata = byte-merge (byte i = m1_wstrb[i] ? m1_wdata byte i : ram_rdata byte i).
  - ram_wen=1 iff m1_wstrb is nonzero; wstrb=0 still completes with an ack.
  - m1_rdata reg is set to 0.
- On grant:
  - last_grant is updated to the granted master.
  - state→RESP; the granted master's resp_valid=1 from the next cycle.
  - Accept-to-response latency is exactly 1 cycle.
- RESP:
  - No new grant; both req_ready=0 and ram_wen=0.
  - resp_valid and rdata are held stable until resp_ready=1.
  - On the resp_valid&resp_ready posedge: resp_valid→0, state→IDLE.
  - Throughput is 1 transaction per 2 cycles minimum.
- No valid request in IDLE: ram_wen=0, RAM addresses don't care (drive 0).
- Requesters may drop req_valid before acceptance; no grant is recorded.

Decomposition:
- Package ram_arbiter_pkg:
  - state encoding ST_IDLE/ST_RESP.
  - master ids MST_IFU=0, MST_LSU=1.
  - function byte_merge(old, new, strb).
- Sub-module ram_arb_rr2: 2-way round-robin picker with last_grant register, grant/update enable.

Test Plan:
- After reset, m0 read addr 0x010 (mem[0x010]=0xDEADBEEF) → m0_req_ready same cycle; next cycle m0_resp_valid=1, m0_rdata=0xDEADBEEF.
- m1 write addr 0x020, wdata 0x11223344, wstrb 4'b0101 onto mem 0xAABBCCDD → ram_wen=1 at accept; mem becomes 0xAA22CC44; m1_resp_valid next cycle with m1_rdata=0.
- Both valid continuously, responses accepted immediately → grants alternate m0,m1,m0,m1, with m0 granted first after reset.
- m0_resp_ready held 0 for 5 cycles → m0_resp_valid and m0_rdata stay stable; no req_ready to m1 during that time; m1 is granted in the cycle after the m0 handshake.
- m1 write with wstrb=0 → ram_wen stays 0, mem unchanged, ack still returned after 1 cycle.
- Assert sys_rst during RESP → next cycle both resp_valid=0, state IDLE, and m0 wins the following contention.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types and helpers for the two-master RAM arbiter.
// Pulled in by the arbiter top and its round-robin picker.
package ram_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    localparam logic MST_IFU = 1'b0;
    localparam logic MST_LSU = 1'b1;

    // One byte lane of a masked write: keep the stored byte unless enabled.
    function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                              input logic [7:0] new_b,
                                              input logic       strb);
        return strb ? new_b : old_b;
    endfunction

endpackage

// File: rtl/ram_arb_rr2.sv
// Two-way round-robin picker. A lone requester always wins; on contention
// the master that did not win last time is chosen.
module ram_arb_rr2
    import ram_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic       grant,
    output logic       grant_valid
);

    logic last_grant;

    always_comb begin
        grant_valid = |req;
        if (&req) begin
            grant = ~last_grant;
        end else begin
            grant = req[1];
        end
    end

    // Reset to LSU so the IFU wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= MST_LSU;
        end else if (update) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares a single-read/single-write word RAM between the instruction fetch
// unit (read-only) and the load/store unit, with registered held responses.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_SIZE = 12,
    parameter int DATA_SIZE = 32
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,

    input  logic                   m0_req_valid,
    output logic                   m0_req_ready,
    input  logic [ADDR_SIZE-1:0]   m0_addr,
    output logic                   m0_resp_valid,
    input  logic                   m0_resp_ready,
    output logic [DATA_SIZE-1:0]   m0_rdata,

    input  logic                   m1_req_valid,
    output logic                   m1_req_ready,
    input  logic                   m1_wr,
    input  logic [ADDR_SIZE-1:0]   m1_addr,
    input  logic [DATA_SIZE-1:0]   m1_wdata,
    input  logic [DATA_SIZE/8-1:0] m1_wstrb,
    output logic                   m1_resp_valid,
    input  logic                   m1_resp_ready,
    output logic [DATA_SIZE-1:0]   m1_rdata,

    output logic [ADDR_SIZE-1:0]   ram_raddr,
    output logic [ADDR_SIZE-1:0]   ram_waddr,
    output logic [DATA_SIZE-1:0]   ram_wdata,
    output logic                   ram_wen,
    input  logic [DATA_SIZE-1:0]   ram_rdata
);

    localparam int STRB_SIZE = DATA_SIZE / 8;

    state_t                state;
    logic                  grant_id;
    logic                  grant_valid;
    logic                  take;
    logic                  wr_go;
    logic [ADDR_SIZE-1:0]  grant_addr;
    logic [DATA_SIZE-1:0]  merged;

    ram_arb_rr2 u_rr (
        .clk         (sys_clk),
        .rst         (sys_rst),
        .req         ({m1_req_valid, m0_req_valid}),
        .update      (take),
        .grant       (grant_id),
        .grant_valid (grant_valid)
    );

    // A grant only happens in IDLE and never while reset is held.
    assign take         = (state == ST_IDLE) && grant_valid && !sys_rst;
    assign m0_req_ready = take && (grant_id == MST_IFU);
    assign m1_req_ready = take && (grant_id == MST_LSU);

    assign grant_addr = (grant_id == MST_LSU) ? m1_addr : m0_addr;
    assign ram_raddr  = take ? grant_addr : '0;
    assign ram_waddr  = take ? grant_addr : '0;

    // Masked writes merge against the current word in the same cycle.
    for (genvar b = 0; b < STRB_SIZE; b++) begin : g_merge
        assign merged[b*8 +: 8] = byte_merge(ram_rdata[b*8 +: 8],
                                             m1_wdata[b*8 +: 8],
                                             m1_wstrb[b]);
    end

    assign wr_go     = m1_req_ready && m1_wr;
    assign ram_wdata = wr_go ? merged : '0;
    assign ram_wen   = wr_go && (|m1_wstrb);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state         <= ST_IDLE;
            m0_resp_valid <= 1'b0;
            m1_resp_valid <= 1'b0;
            m0_rdata      <= '0;
            m1_rdata      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        state <= ST_RESP;
                        if (grant_id == MST_IFU) begin
                            m0_resp_valid <= 1'b1;
                            m0_rdata      <= ram_rdata;
                        end else begin
                            m1_resp_valid <= 1'b1;
                            m1_rdata      <= m1_wr ? '0 : ram_rdata;
                        end
                    end
                end
                ST_RESP: begin
                    // Only one response is ever outstanding.
                    if (m0_resp_valid && m0_resp_ready) begin
                        m0_resp_valid <= 1'b0;
                        state         <= ST_IDLE;
                    end else if (m1_resp_valid && m1_resp_ready) begin
                        m1_resp_valid <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: stimulus drives the masters, a negedge
// monitor scores responses against a private memory model.
module tb_ram_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          m0_req_valid, m0_req_ready, m0_resp_valid, m0_resp_ready;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_rdata;
    logic          m1_req_valid, m1_req_ready, m1_wr, m1_resp_valid, m1_resp_ready;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic [SW-1:0] m1_wstrb;
    logic [AW-1:0] ram_raddr, ram_waddr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic          ram_wen;

    logic [DW-1:0] mem   [0:(1<<AW)-1];
    logic [DW-1:0] model [0:(1<<AW)-1];

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int            grants[$];
    logic          m0_wait, m1_wait;
    logic [DW-1:0] m0_held, m1_held;

    ram_arbiter #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
        .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready), .m0_rdata(m0_rdata),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_wr(m1_wr),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready), .m1_rdata(m1_rdata),
        .ram_raddr(ram_raddr), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_wen(ram_wen), .ram_rdata(ram_rdata)
    );

    always #5 sys_clk = ~sys_clk;

    assign ram_rdata = mem[ram_raddr];
    always @(posedge sys_clk) begin
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
    end

    function automatic logic [DW-1:0] init_word(input int a);
        logic [DW-1:0] x;
        x = a;
        if (a == 'h010) return 32'hDEADBEEF;
        if (a == 'h020) return 32'hAABBCCDD;
        return {x[15:0], ~x[15:0]};
    endfunction

    function automatic logic [DW-1:0] model_merge(input logic [DW-1:0] old_w,
                                                  input logic [DW-1:0] new_w,
                                                  input logic [SW-1:0] strb);
        logic [DW-1:0] mask;
        mask = '0;
        for (int b = 0; b < SW; b++) if (strb[b]) mask[b*8 +: 8] = 8'hFF;
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got unexpected event expected none", nm);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1<<AW); i++) begin
            mem[i]   <= init_word(i);
            model[i]  = init_word(i);
        end
    end

    // Monitor: record grants, predict responses, score handshakes.
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            m0_wait = 1'b0;
            m1_wait = 1'b0;
        end else begin
            if (m0_req_ready || m1_req_ready)
                check("one_ready", {1'b0, m0_req_ready & m1_req_ready}, 0);
            if (m0_req_ready) begin
                grants.push_back(0);
                q0.push_back(model[m0_addr]);
            end
            if (m1_req_ready) begin
                grants.push_back(1);
                if (m1_wr) begin
                    q1.push_back('0);
                    model[m1_addr] = model_merge(model[m1_addr], m1_wdata, m1_wstrb);
                end else begin
                    q1.push_back(model[m1_addr]);
                end
            end
            if (m0_resp_valid && m0_wait) check("m0_stable", m0_rdata, m0_held);
            if (m1_resp_valid && m1_wait) check("m1_stable", m1_rdata, m1_held);
            if (m0_resp_valid && m0_resp_ready) begin
                if (q0.size() == 0) fail_now("m0_unexpected_resp");
                else check("m0_sb_rdata", m0_rdata, q0.pop_front());
            end
            if (m1_resp_valid && m1_resp_ready) begin
                if (q1.size() == 0) fail_now("m1_unexpected_resp");
                else check("m1_sb_rdata", m1_rdata, q1.pop_front());
            end
            m0_wait = m0_resp_valid && !m0_resp_ready;
            m1_wait = m1_resp_valid && !m1_resp_ready;
            m0_held = m0_rdata;
            m1_held = m1_rdata;
        end
    end

    initial begin
        sys_rst = 1'b1;
        m0_req_valid = 1'b0; m0_addr = '0; m0_resp_ready = 1'b1;
        m1_req_valid = 1'b0; m1_wr = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        m1_resp_ready = 1'b1;
        tick(); tick();
        sys_rst = 1'b0;

        // Reset state
        @(negedge sys_clk);
        check("rst_m0_resp_valid", m0_resp_valid, 0);
        check("rst_m1_resp_valid", m1_resp_valid, 0);
        check("rst_m0_rdata", m0_rdata, 0);
        check("rst_m1_rdata", m1_rdata, 0);
        check("rst_ram_wen", ram_wen, 0);

        // m0 read of 0x010
        tick();
        m0_req_valid = 1'b1; m0_addr = 12'h010;
        @(negedge sys_clk);
        check("m0_rd_ready", m0_req_ready, 1);
        check("m0_rd_raddr", ram_raddr, 12'h010);
        tick();
        m0_req_valid = 1'b0;
        @(negedge sys_clk);
        check("m0_rd_resp_valid", m0_resp_valid, 1);
        check("m0_rd_rdata", m0_rdata, 32'hDEADBEEF);

        // m1 masked write 0x020
        tick();
        m1_req_valid = 1'b1; m1_wr = 1'b1; m1_addr = 12'h020;
        m1_wdata = 32'h11223344; m1_wstrb = 4'b0101;
        @(negedge sys_clk);
        check("m1_wr_ready", m1_req_ready, 1);
        check("m1_wr_wen", ram_wen, 1);
        check("m1_wr_waddr", ram_waddr, 12'h020);
        check("m1_wr_wdata", ram_wdata, 32'hAA22CC44);
        tick();
        m1_req_valid = 1'b0;
        @(negedge sys_clk);
        check("m1_wr_mem", mem[12'h020], 32'hAA22CC44);
        check("m1_wr_resp_valid", m1_resp_valid, 1);
        check("m1_wr_rdata", m1_rdata, 0);

        // m1 read back
        tick();
        m1_req_valid = 1'b1; m1_wr = 1'b0; m1_addr = 12'h020;
        @(negedge sys_clk);
        check("m1_rd_ready", m1_req_ready, 1);
        tick();
        m1_req_valid = 1'b0;
        @(negedge sys_clk);
        check("m1_rd_rdata", m1_rdata, 32'hAA22CC44);

        // Round-robin under continuous contention, from reset
        tick();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        q0.delete(); q1.delete(); grants.delete();
        m0_req_valid = 1'b1; m0_addr = 12'h010;
        m1_req_valid = 1'b1; m1_wr = 1'b0; m1_addr = 12'h030;
        repeat (8) tick();
        m0_req_valid = 1'b0; m1_req_valid = 1'b0;
        @(negedge sys_clk);
        check("rr_count", grants.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < grants.size()) check($sformatf("rr_grant%0d", i), grants[i], i % 2);

        // m0 response stall blocks m1
        tick();
        m0_resp_ready = 1'b0;
        m0_req_valid = 1'b1; m0_addr = 12'h040;
        @(negedge sys_clk);
        check("stall_m0_ready", m0_req_ready, 1);
        tick();
        m0_req_valid = 1'b0;
        m1_req_valid = 1'b1; m1_wr = 1'b0; m1_addr = 12'h041;
        for (int k = 0; k < 5; k++) begin
            @(negedge sys_clk);
            check("stall_m0_valid", m0_resp_valid, 1);
            check("stall_m0_rdata", m0_rdata, init_word('h040));
            check("stall_m1_ready", m1_req_ready, 0);
            tick();
        end
        m0_resp_ready = 1'b1;
        @(negedge sys_clk);
        check("stall_hs_m1_ready", m1_req_ready, 0);
        tick();
        @(negedge sys_clk);
        check("stall_after_m1_ready", m1_req_ready, 1);
        tick();
        m1_req_valid = 1'b0;

        // Write with empty strobe
        tick();
        m1_req_valid = 1'b1; m1_wr = 1'b1; m1_addr = 12'h050;
        m1_wdata = 32'hFFFFFFFF; m1_wstrb = 4'b0000;
        @(negedge sys_clk);
        check("nostrb_ready", m1_req_ready, 1);
        check("nostrb_wen", ram_wen, 0);
        tick();
        m1_req_valid = 1'b0;
        @(negedge sys_clk);
        check("nostrb_resp_valid", m1_resp_valid, 1);
        check("nostrb_rdata", m1_rdata, 0);
        check("nostrb_mem", mem[12'h050], init_word('h050));

        // Reset during RESP after an m0 grant
        tick();
        m0_resp_ready = 1'b0;
        m0_req_valid = 1'b1; m0_addr = 12'h060;
        @(negedge sys_clk);
        check("rstresp_m0_ready", m0_req_ready, 1);
        tick();
        m0_req_valid = 1'b0;
        @(negedge sys_clk);
        check("rstresp_pending", m0_resp_valid, 1);
        tick();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        q0.delete(); q1.delete();
        m0_resp_ready = 1'b1;
        m0_req_valid = 1'b1; m0_addr = 12'h010;
        m1_req_valid = 1'b1; m1_wr = 1'b0; m1_addr = 12'h030;
        @(negedge sys_clk);
        check("rstresp_m0_valid", m0_resp_valid, 0);
        check("rstresp_m1_valid", m1_resp_valid, 0);
        check("rstresp_m0_wins", m0_req_ready, 1);
        check("rstresp_m1_wait", m1_req_ready, 0);
        tick();
        m0_req_valid = 1'b0; m1_req_valid = 1'b0;

        // Drain outstanding responses
        for (int k = 0; k < 20 && (q0.size() != 0 || q1.size() != 0); k++) tick();
        check("drain_q0", q0.size(), 0);
        check("drain_q1", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
